// File: rtl/clk_ratio_pkg.sv
// Shared definitions for the clock ratio detector: ratio codes, nominal
// periods, FSM state type and the period classifier.
package clk_ratio_pkg;

  // Ratio codes match the select encoding of the selectable clock divider.
  localparam logic [1:0] RATIO_DIV2  = 2'b00;
  localparam logic [1:0] RATIO_DIV4  = 2'b01;
  localparam logic [1:0] RATIO_DIV8  = 2'b11;
  localparam logic [1:0] RATIO_DIV16 = 2'b10;

  // Nominal periods in system clock cycles.
  localparam logic [31:0] PERIOD_DIV2  = 32'd2;
  localparam logic [31:0] PERIOD_DIV4  = 32'd4;
  localparam logic [31:0] PERIOD_DIV8  = 32'd8;
  localparam logic [31:0] PERIOD_DIV16 = 32'd16;

  typedef enum logic [1:0] {
    StIdle,
    StAcquire,
    StLocked
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } ratio_class_t;

  // Map a measured period to its ratio code; anything off-nominal is invalid.
  function automatic ratio_class_t classify(input logic [31:0] period);
    ratio_class_t c;
    c.valid = 1'b1;
    c.code  = RATIO_DIV2;
    case (period)
      PERIOD_DIV2:  c.code = RATIO_DIV2;
      PERIOD_DIV4:  c.code = RATIO_DIV4;
      PERIOD_DIV8:  c.code = RATIO_DIV8;
      PERIOD_DIV16: c.code = RATIO_DIV16;
      default:      c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/clk_ratio_detector_if.sv
// Bundle of the divided clock under test and all detector results.
// master: the side that drives the divided clock and consumes results.
// slave: the detector itself.
interface clk_ratio_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sig_in;
  logic [1:0]       ratio;
  logic             locked;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic             err;
  logic             timeout;

  modport master (
    output sig_in,
    input  ratio, locked, meas_valid, period, err, timeout
  );

  modport slave (
    input  sig_in,
    output ratio, locked, meas_valid, period, err, timeout
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with a single-cycle rising-edge pulse on the
// synchronized signal.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d_q;

  // Shift the async input through the synchronizer and keep one delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      synced_d_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], d};
      synced_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~synced_d_q;

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures the period of a divided clock in system clock cycles, decodes it
// back to the divider select code and reports lock, error and timeout.
module clk_ratio_detector
  import clk_ratio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  clk_ratio_detector_if.slave  bus
);

  logic rise;

  state_e           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [1:0]       ratio_q, ratio_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  ratio_class_t cls;
  logic         expired;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.sig_in),
    .rise(rise)
  );

  assign cls     = classify(32'(period_cnt_q));
  assign expired = (period_cnt_q == CNT_W'(TIMEOUT));

  // Next-state logic: period counter, FSM transitions and output pulses.
  always_comb begin
    logic [3:0] match_inc;
    state_d      = state_q;
    cand_d       = cand_q;
    match_d      = match_q;
    ratio_d      = ratio_q;
    locked_d     = locked_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    timeout_d    = 1'b0;
    match_inc    = match_q + 4'd1;

    // Counter saturates at TIMEOUT so it can never wrap.
    if (rise) begin
      period_cnt_d = CNT_W'(1);
    end else if (!expired) begin
      period_cnt_d = period_cnt_q + CNT_W'(1);
    end else begin
      period_cnt_d = period_cnt_q;
    end

    unique case (state_q)
      StIdle: begin
        // First edge only starts the counter; nothing is captured.
        if (rise) begin
          state_d = StAcquire;
          match_d = 4'd0;
        end
      end
      StAcquire: begin
        if (rise) begin
          period_d     = period_cnt_q;
          meas_valid_d = 1'b1;
          if (cls.valid) begin
            if (cls.code == cand_q) begin
              match_d = match_inc;
            end else begin
              cand_d  = cls.code;
              match_d = 4'd1;
            end
            if (match_d == 4'(LOCK_COUNT)) begin
              state_d  = StLocked;
              ratio_d  = cand_d;
              locked_d = 1'b1;
            end
          end else begin
            match_d = 4'd0;
            err_d   = 1'b1;
          end
        end else if (expired) begin
          state_d   = StIdle;
          locked_d  = 1'b0;
          match_d   = 4'd0;
          timeout_d = 1'b1;
        end
      end
      StLocked: begin
        if (rise) begin
          period_d     = period_cnt_q;
          meas_valid_d = 1'b1;
          if (cls.valid) begin
            if (cls.code != ratio_q) begin
              state_d  = StAcquire;
              locked_d = 1'b0;
              cand_d   = cls.code;
              match_d  = 4'd1;
            end
          end else begin
            state_d  = StAcquire;
            locked_d = 1'b0;
            match_d  = 4'd0;
            err_d    = 1'b1;
          end
        end else if (expired) begin
          state_d   = StIdle;
          locked_d  = 1'b0;
          match_d   = 4'd0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cand_q       <= RATIO_DIV2;
      match_q      <= 4'd0;
      period_cnt_q <= '0;
      ratio_q      <= RATIO_DIV2;
      locked_q     <= 1'b0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      match_q      <= match_d;
      period_cnt_q <= period_cnt_d;
      ratio_q      <= ratio_d;
      locked_q     <= locked_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.ratio      = ratio_q;
  assign bus.locked     = locked_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.period     = period_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Directed testbench for clk_ratio_detector: drives divided-clock waveforms
// and checks captures, lock, error and timeout against hand-computed values.
module tb_clk_ratio_detector;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 64;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic             locked;
    logic [1:0]       ratio;
    logic             err;
  } cap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_ratio_detector_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_detector #(
    .SYNC_STAGES(2),
    .LOCK_COUNT (4),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   failures  = 0;
  cap_t entries[$];
  int   err_cnt   = 0;
  int   to_cnt    = 0;
  int   mv_cnt    = 0;
  int   lock_caps = -1;
  int   cyc       = 0;
  int   last_mv_cyc = 0;
  int   to_cyc    = 0;
  logic prev_locked = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Sample outputs on the falling edge and log every capture and pulse.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_locked = 1'b0;
    end else begin
      if (bus.meas_valid) begin
        entries.push_back('{period: bus.period, locked: bus.locked,
                            ratio: bus.ratio, err: bus.err});
        mv_cnt++;
        last_mv_cyc = cyc;
      end
      if (bus.err) err_cnt++;
      if (bus.timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (bus.locked && !prev_locked && lock_caps < 0) lock_caps = mv_cnt;
      prev_locked = bus.locked;
    end
  end

  task automatic clear_log();
    entries.delete();
    err_cnt   = 0;
    to_cnt    = 0;
    mv_cnt    = 0;
    lock_caps = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
  endtask

  // One divided-clock period: p/2 cycles high then p/2 cycles low.
  task automatic send_period(input int p);
    bus.sig_in = 1'b1;
    repeat (p / 2) begin @(posedge clk); #1; end
    bus.sig_in = 1'b0;
    repeat (p / 2) begin @(posedge clk); #1; end
  endtask

  task automatic send_n(input int p, input int n);
    for (int i = 0; i < n; i++) send_period(p);
  endtask

  task automatic settle();
    repeat (10) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_periods(input string tag, input int exp);
    for (int i = 0; i < entries.size(); i++) check(tag, entries[i].period, exp);
  endtask

  initial begin
    bus.sig_in = 1'b0;

    // Reset values
    do_reset();
    check("rst_ratio", bus.ratio, 2'b00);
    check("rst_locked", bus.locked, 0);
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_period", bus.period, 0);
    check("rst_err", bus.err, 0);
    check("rst_timeout", bus.timeout, 0);

    // Divide by 2: 8 rises -> 7 captures of 2, lock on the 4th capture
    send_n(2, 8);
    settle();
    check("div2_caps", entries.size(), 7);
    check_all_periods("div2_period", 2);
    check("div2_lock_at", lock_caps, 4);
    check("div2_locked", bus.locked, 1);
    check("div2_ratio", bus.ratio, 2'b00);
    check("div2_err", err_cnt, 0);
    check("div2_timeout", to_cnt, 0);

    // Divide by 16
    do_reset();
    send_n(16, 8);
    settle();
    check("div16_caps", entries.size(), 7);
    check_all_periods("div16_period", 16);
    check("div16_lock_at", lock_caps, 4);
    check("div16_locked", bus.locked, 1);
    check("div16_ratio", bus.ratio, 2'b10);

    // Switch /4 -> /8 while locked; captures 7..11 are period 8
    do_reset();
    send_n(4, 6);
    send_n(8, 6);
    settle();
    check("sw_caps", entries.size(), 11);
    check("sw_cap6_locked", entries[5].locked, 1);
    check("sw_cap6_ratio", entries[5].ratio, 2'b01);
    check("sw_cap7_period", entries[6].period, 8);
    check("sw_cap7_locked", entries[6].locked, 0);
    check("sw_cap7_ratio", entries[6].ratio, 2'b01);
    check("sw_cap9_locked", entries[8].locked, 0);
    check("sw_cap9_ratio", entries[8].ratio, 2'b01);
    check("sw_cap10_locked", entries[9].locked, 1);
    check("sw_cap10_ratio", entries[9].ratio, 2'b11);
    check("sw_err", err_cnt, 0);

    // Bad period of 6 while locked at /4
    do_reset();
    send_n(4, 6);
    send_period(6);
    send_n(4, 5);
    settle();
    check("bad_caps", entries.size(), 11);
    check("bad_cap7_period", entries[6].period, 6);
    check("bad_cap7_err", entries[6].err, 1);
    check("bad_cap7_locked", entries[6].locked, 0);
    check("bad_err_cnt", err_cnt, 1);
    check("bad_cap10_locked", entries[9].locked, 0);
    check("bad_cap11_locked", entries[10].locked, 1);
    check("bad_cap11_ratio", entries[10].ratio, 2'b01);

    // Hold low while locked: one timeout TIMEOUT cycles after last capture
    repeat (3 * TIMEOUT) begin @(posedge clk); #1; end
    check("to_cnt", to_cnt, 1);
    check("to_delay", to_cyc - last_mv_cyc, TIMEOUT);
    check("to_locked", bus.locked, 0);
    check("to_ratio_held", bus.ratio, 2'b01);
    send_period(4);
    settle();
    check("to_no_capture", entries.size(), 11);
    check("to_no_err", err_cnt, 1);

    // Async reset while locked at /8
    do_reset();
    send_n(8, 6);
    settle();
    check("ar_pre_locked", bus.locked, 1);
    check("ar_pre_ratio", bus.ratio, 2'b11);
    #3 rst = 1'b1;
    #1;
    check("ar_ratio", bus.ratio, 2'b00);
    check("ar_locked", bus.locked, 0);
    check("ar_period", bus.period, 0);
    check("ar_meas_valid", bus.meas_valid, 0);
    check("ar_err", bus.err, 0);
    check("ar_timeout", bus.timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_log();
    send_n(8, 6);
    settle();
    check("ar_relock_at", lock_caps, 4);
    check("ar_relocked", bus.locked, 1);
    check("ar_reratio", bus.ratio, 2'b11);
    check_all_periods("ar_period8", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_ratio_detector.md
Name: clk_ratio_detector

Overview:
- Receive-side counterpart of the selectable clock divider.
- Takes a divided clock derived from `clk`, measures its period in `clk` cycles, and decodes it back to the 2-bit divider select code.
- Reports lock once the ratio is stable, plus error and timeout indications.
- Used as a loopback/self-check monitor on the divider output, and by downstream logic that must learn the active ratio.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in` (minimum 2).
- LOCK_COUNT, 4, consecutive identical valid periods required to assert lock (1..15).
- TIMEOUT, 64, cycles without a rising edge before returning to idle (must exceed 16, must be below 2^CNT_W).
- CNT_W, 8, width of the period counter and the `period` output.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  divided clock under test; synchronized internally.
- ratio  out  2  decoded select code: 00 = /2, 01 = /4, 11 = /8, 10 = /16.
- locked  out  1  high while `ratio` is confirmed.
- meas_valid  out  1  one-cycle pulse when a new period is captured.
- period  out  CNT_W  last captured period in `clk` cycles.
- err  out  1  one-cycle pulse when a captured period is not 2, 4, 8 or 16.
- timeout  out  1  one-cycle pulse when TIMEOUT expires.

Behaviour:
- Reset: async, active-high; all flops clear immediately.
  - Outputs reset to `ratio` = 00, `locked` = 0, `meas_valid` = 0, `period` = 0, `err` = 0, `timeout` = 0.
  - FSM resets to IDLE; `cand` = 00, `match_cnt` = 0, `period_cnt` = 0, synchronizer = 0.
- Synchronizer: `sig_in` passes through SYNC_STAGES flops; `rise` = synced & ~synced_d. This adds a fixed latency of SYNC_STAGES+1 cycles and does not affect the measured period.
- Period counter `period_cnt`, CNT_W bits:
  - On `rise`: capture `period_cnt` into `period` (except in IDLE), pulse `meas_valid`, load `period_cnt` = 1.
  - Otherwise: increment, saturating at TIMEOUT.
  - A square wave toggling every cycle therefore captures 2; /16 captures 16.
- Classification of a captured value: 2→00, 4→01, 8→11, 16→10; any other value is invalid.
- FSM states IDLE, ACQUIRE, LOCKED.
  - IDLE:
    - The first `rise` produces no capture, no `meas_valid` and no `err`; it only starts the counter.
    - Go to ACQUIRE with `match_cnt` = 0.
  - ACQUIRE, on `rise`:
    - Valid class equal to `cand`: `match_cnt`++.
    - Valid class different from `cand`: `cand` = class, `match_cnt` = 1.
    - Invalid class: `match_cnt` = 0, pulse `err`.
    - When `match_cnt` would reach LOCK_COUNT: go to LOCKED, `ratio` <= `cand`, `locked` <= 1 on the same clock edge.
  - LOCKED, on `rise`:
    - Class equal to `ratio`: stay.
    - Different valid class: go to ACQUIRE, `locked` = 0, `cand` = new class, `match_cnt` = 1.
    - Invalid class: go to ACQUIRE, `locked` = 0, `match_cnt` = 0, pulse `err`.
  - `ratio` holds its last locked value while unlocked.
  - Any state except IDLE: `period_cnt` == TIMEOUT with no `rise` → go to IDLE, `locked` = 0, `match_cnt` = 0, one `timeout` pulse. While in IDLE, further saturation produces no repeat pulse.
- Simultaneous events: `rise` in the same cycle as timeout expiry → the rise wins and no timeout occurs.
- Counter wrap: impossible; the counter saturates at TIMEOUT.
- Lock latency: LOCK_COUNT+1 rising edges after leaving IDLE, plus synchronizer latency. `locked` is registered.
- Reset mid-operation: immediate return to reset values, no pulses emitted.

Decomposition:
- Shared package `clk_ratio_pkg`:
  - Ratio code constants RATIO_DIV2/4/8/16 (must match the divider select encoding).
  - Nominal periods 2/4/8/16.
  - FSM state typedef.
- One sub-module, `sync_edge_detect`: parameterized SYNC_STAGES synchronizer plus rising-edge pulse, with async reset.

Test Plan:
- /2 input, square wave toggling every `clk`, after reset:
  - `period` = 2 on every `meas_valid`.
  - `locked` rises after the 5th synced rising edge with `ratio` = 00.
  - `err` and `timeout` never pulse.
- /16 input, 8 high / 8 low: `period` = 16; `locked` = 1 with `ratio` = 10 after 5 edges.
- Switch from /4 to /8 while locked:
  - First 8-cycle capture drops `locked` the next cycle.
  - Relock after 4 periods of 8 with `ratio` = 11.
  - `ratio` stays 01 in between.
- Period 6 inserted while locked at /4: `err` pulses once, `locked` drops; relock at 01 after 4 further good periods.
- Hold `sig_in` low while locked: `timeout` pulses exactly once, TIMEOUT cycles after the last captured edge; `locked` = 0; FSM in IDLE. The next edge produces no capture.
- Assert `rst` asynchronously (between clock edges) while locked at /8: all outputs read reset values immediately; after release, lock is re-acquired from IDLE.
